// File: rtl/ps2_color_ctrl.sv
// PS/2 set-2 scancode interpreter driving three saturating VGA colour channels.
// Optional build macro PS2_COLOR_TYPEMATIC_EN: typematic repeats of '=' / '-' keep ramping.
module ps2_color_ctrl #(
  parameter int WIDTH       = 10,
  parameter int STEP        = 100,
  parameter int INC         = 32,
  parameter int RESET_LEVEL = 0
) (
  input  logic             CLK_50,
  input  logic             Rst,
  input  logic [7:0]       iCode,
  input  logic             iCodeReady,
  output logic [WIDTH-1:0] oRed,
  output logic [WIDTH-1:0] oGreen,
  output logic [WIDTH-1:0] oBlue,
  output logic [1:0]       oSel,
  output logic [7:0]       oKey,
  output logic             oUpdate
);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;
  typedef enum logic [1:0] {OP_HOLD, OP_SET, OP_INC, OP_DEC} op_t;

  localparam logic [WIDTH-1:0] MAXV   = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   INC_W  = (WIDTH+1)'(INC);
  localparam logic [WIDTH-1:0] RST_LV = WIDTH'(RESET_LEVEL);

  // Saturating channel update, computed one bit wider than the channel.
  function automatic logic [WIDTH-1:0] next_level(input logic [WIDTH-1:0] cur,
                                                  input op_t op,
                                                  input logic [WIDTH-1:0] lvl);
    logic [WIDTH:0] t;
    t = '0;
    case (op)
      OP_SET:  return lvl;
      OP_INC: begin
        t = {1'b0, cur} + INC_W;
        return t[WIDTH] ? MAXV : t[WIDTH-1:0];
      end
      OP_DEC: begin
        t = {1'b0, cur} - INC_W;
        return t[WIDTH] ? '0 : t[WIDTH-1:0];
      end
      default: return cur;
    endcase
  endfunction

  function automatic int digit_of(input logic [7:0] c);
    case (c)
      8'h16: return 1;
      8'h1E: return 2;
      8'h26: return 3;
      8'h25: return 4;
      8'h2E: return 5;
      8'h36: return 6;
      8'h3D: return 7;
      8'h3E: return 8;
      8'h46: return 9;
      default: return 0;
    endcase
  endfunction

  logic             sync1_q, sync2_q, sync3_q;
  logic             rise;
  logic [7:0]       code_q;
  logic             code_vld_q;

  state_t           state_q;
  logic [7:0]       held_q;
  logic [7:0]       key_q;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] red_q, green_q, blue_q;
  logic [WIDTH-1:0] red_d, green_d, blue_d;
  logic             upd_q;

  op_t              op;
  logic [WIDTH-1:0] lvl;
  logic             is_sel;
  logic [1:0]       sel_cmd;
  logic             make_vld;
  logic             repeat_key;
  logic             ramp_ok;
  logic             apply_en;
  logic             changed;

  assign rise = sync2_q & ~sync3_q;

  // Ready synchroniser and edge detect; code is captured on the detected edge.
  always_ff @(posedge CLK_50) begin
    if (Rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      code_vld_q <= 1'b0;
    end else begin
      sync1_q    <= iCodeReady;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      code_vld_q <= rise;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (rise) code_q <= iCode;
  end

  always_comb begin
    op      = OP_HOLD;
    lvl     = '0;
    is_sel  = 1'b0;
    sel_cmd = sel_q;
    case (code_q)
      8'h2D: begin is_sel = 1'b1; sel_cmd = 2'd0; end
      8'h34: begin is_sel = 1'b1; sel_cmd = 2'd1; end
      8'h32: begin is_sel = 1'b1; sel_cmd = 2'd2; end
      8'h1C: begin is_sel = 1'b1; sel_cmd = 2'd3; end
      8'h45: begin op = OP_SET; lvl = MAXV; end
      8'h0E: begin op = OP_SET; lvl = '0; end
      8'h55: op = OP_INC;
      8'h4E: op = OP_DEC;
      default: begin
        if (digit_of(code_q) != 0) begin
          op  = OP_SET;
          lvl = WIDTH'(digit_of(code_q) * STEP);
        end
      end
    endcase
  end

  always_comb begin
    make_vld   = code_vld_q && (state_q == S_IDLE) &&
                 (code_q != 8'hF0) && (code_q != 8'hE0);
    repeat_key = (code_q == held_q);
`ifdef PS2_COLOR_TYPEMATIC_EN
    ramp_ok    = (op == OP_INC) || (op == OP_DEC);
`else
    ramp_ok    = 1'b0;
`endif
    apply_en   = make_vld && (!repeat_key || ramp_ok);

    sel_d   = sel_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (apply_en) begin
      if (is_sel) sel_d = sel_cmd;
      if (sel_q == 2'd0 || sel_q == 2'd3) red_d   = next_level(red_q,   op, lvl);
      if (sel_q == 2'd1 || sel_q == 2'd3) green_d = next_level(green_q, op, lvl);
      if (sel_q == 2'd2 || sel_q == 2'd3) blue_d  = next_level(blue_q,  op, lvl);
    end
    changed = (red_d != red_q) || (green_d != green_q) || (blue_d != blue_q);
  end

  // Decode FSM with registered colour, select, key and update outputs.
  always_ff @(posedge CLK_50) begin
    if (Rst) begin
      state_q <= S_IDLE;
      held_q  <= 8'h00;
      key_q   <= 8'h00;
      sel_q   <= 2'd0;
      red_q   <= RST_LV;
      green_q <= RST_LV;
      blue_q  <= RST_LV;
      upd_q   <= 1'b0;
    end else begin
      upd_q   <= changed;
      sel_q   <= sel_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      if (code_vld_q) begin
        case (state_q)
          S_IDLE: begin
            if (code_q == 8'hF0)      state_q <= S_BRK;
            else if (code_q == 8'hE0) state_q <= S_EXT;
            else begin
              key_q  <= code_q;
              held_q <= code_q;
            end
          end
          S_BRK: begin
            if (code_q == held_q) held_q <= 8'h00;
            state_q <= S_IDLE;
          end
          S_EXT:   state_q <= (code_q == 8'hF0) ? S_EXT_BRK : S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign oRed    = red_q;
  assign oGreen  = green_q;
  assign oBlue   = blue_q;
  assign oSel    = sel_q;
  assign oKey    = key_q;
  assign oUpdate = upd_q;

endmodule

// File: tb/tb_ps2_color_ctrl.sv
// Self-checking bench for ps2_color_ctrl: directed vector table plus random codes vs a reference model.
module tb_ps2_color_ctrl;

  localparam int WIDTH = 10;
  localparam int STEP  = 100;
  localparam int INC   = 32;
  localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef PS2_COLOR_TYPEMATIC_EN
  localparam bit TYP = 1'b1;
`else
  localparam bit TYP = 1'b0;
`endif

  logic             CLK_50 = 1'b0;
  logic             Rst = 1'b1;
  logic [7:0]       iCode = 8'h00;
  logic             iCodeReady = 1'b0;
  logic [WIDTH-1:0] oRed, oGreen, oBlue;
  logic [1:0]       oSel;
  logic [7:0]       oKey;
  logic             oUpdate;

  ps2_color_ctrl #(.WIDTH(WIDTH), .STEP(STEP), .INC(INC), .RESET_LEVEL(0)) dut (
    .CLK_50(CLK_50), .Rst(Rst), .iCode(iCode), .iCodeReady(iCodeReady),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oSel(oSel), .oKey(oKey), .oUpdate(oUpdate)
  );

  always #5 CLK_50 = ~CLK_50;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Reference model: channel values as plain integers, prefix tracking as a mode number.
  int m_ch[3];
  int m_sel, m_key, m_held, m_mode, m_upd;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_ch[i] = 0;
    m_sel = 0; m_key = 0; m_held = 0; m_mode = 0; m_upd = 0;
  endtask

  function automatic int digit_val(input int c);
    int keys[9] = '{'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
    for (int i = 0; i < 9; i++) if (keys[i] == c) return i + 1;
    return 0;
  endfunction

  function automatic int new_val(input int c, input int v);
    if (digit_val(c) != 0) return digit_val(c) * STEP;
    if (c == 'h45) return MAXV;
    if (c == 'h0E) return 0;
    if (c == 'h55) return (v + INC > MAXV) ? MAXV : v + INC;
    if (c == 'h4E) return (v - INC < 0) ? 0 : v - INC;
    return v;
  endfunction

  task automatic model_make(input int c);
    bit rep;
    int old;
    rep    = (c == m_held);
    m_held = c;
    m_key  = c;
    if (rep && !(TYP && (c == 'h55 || c == 'h4E))) return;
    case (c)
      'h2D: m_sel = 0;
      'h34: m_sel = 1;
      'h32: m_sel = 2;
      'h1C: m_sel = 3;
      default: begin
        for (int i = 0; i < 3; i++) begin
          if (m_sel == 3 || m_sel == i) begin
            old     = m_ch[i];
            m_ch[i] = new_val(c, old);
            if (m_ch[i] != old) m_upd = 1;
          end
        end
      end
    endcase
  endtask

  task automatic model_code(input int c);
    m_upd = 0;
    case (m_mode)
      1: begin if (c == m_held) m_held = 0; m_mode = 0; end
      2: m_mode = (c == 'hF0) ? 3 : 0;
      3: m_mode = 0;
      default: begin
        if (c == 'hF0)      m_mode = 1;
        else if (c == 'hE0) m_mode = 2;
        else                model_make(c);
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".red"},   int'(oRed),   m_ch[0]);
    chk({tag, ".green"}, int'(oGreen), m_ch[1]);
    chk({tag, ".blue"},  int'(oBlue),  m_ch[2]);
    chk({tag, ".sel"},   int'(oSel),   m_sel);
    chk({tag, ".key"},   int'(oKey),   m_key);
    chk({tag, ".upd"},   int'(oUpdate), m_upd);
  endtask

  task automatic do_reset();
    @(negedge CLK_50);
    Rst = 1'b1; iCodeReady = 1'b0;
    repeat (2) @(negedge CLK_50);
    Rst = 1'b0;
    model_reset();
  endtask

  // Ready rises before edge n; outputs must hold through n+2, change at n+3, pulse ends at n+4.
  task automatic send(input logic [7:0] c);
    int pr;
    @(negedge CLK_50);
    iCode = c;
    @(negedge CLK_50);
    iCodeReady = 1'b1;
    pr = m_ch[0];
    model_code(int'(c));
    repeat (3) @(posedge CLK_50);
    #1;
    chk("early.upd", int'(oUpdate), 0);
    chk("early.red", int'(oRed), pr);
    @(posedge CLK_50);
    #1;
    check_all("n3");
    @(posedge CLK_50);
    #1;
    chk("late.upd", int'(oUpdate), 0);
    @(negedge CLK_50);
    iCodeReady = 1'b0;
    repeat (3) @(negedge CLK_50);
  endtask

  typedef struct {
    logic [7:0] code;
    int r, g, b, sel, key, upd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [7:0] c, input int r, g, b, sel, key, upd);
    vec_t v;
    v.code = c; v.r = r; v.g = g; v.b = b; v.sel = sel; v.key = key; v.upd = upd;
    tbl.push_back(v);
  endtask

  logic [7:0] pool[16] = '{8'h2D, 8'h34, 8'h32, 8'h1C, 8'h55, 8'h55, 8'h4E, 8'h4E,
                           8'h45, 8'h0E, 8'h16, 8'h3D, 8'hF0, 8'hE0, 8'h75, 8'h29};

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add(8'h32, 0, 0, 0, 2, 'h32, 0);
    add(8'h26, 0, 0, 300, 2, 'h26, 1);
    add(8'h1C, 0, 0, 300, 3, 'h1C, 0);
    add(8'h45, 1023, 1023, 1023, 3, 'h45, 1);
    add(8'h1C, 1023, 1023, 1023, 3, 'h1C, 0);
    add(8'h4E, 991, 991, 991, 3, 'h4E, 1);
    add(8'h2D, 991, 991, 991, 0, 'h2D, 0);
    add(8'h0E, 0, 991, 991, 0, 'h0E, 1);
    add(8'h4E, 0, 991, 991, 0, 'h4E, 0);
    add(8'hE0, 0, 991, 991, 0, 'h4E, 0);
    add(8'h75, 0, 991, 991, 0, 'h4E, 0);
    add(8'hE0, 0, 991, 991, 0, 'h4E, 0);
    add(8'hF0, 0, 991, 991, 0, 'h4E, 0);
    add(8'h75, 0, 991, 991, 0, 'h4E, 0);
    add(8'hF0, 0, 991, 991, 0, 'h4E, 0);
    add(8'h2D, 0, 991, 991, 0, 'h4E, 0);
    add(8'h16, 100, 991, 991, 0, 'h16, 1);
    add(8'h0E, 0, 991, 991, 0, 'h0E, 1);
    add(8'h55, 32, 991, 991, 0, 'h55, 1);
    add(8'h55, TYP ? 64 : 32, 991, 991, 0, 'h55, TYP ? 1 : 0);
    add(8'h55, TYP ? 96 : 32, 991, 991, 0, 'h55, TYP ? 1 : 0);
    add(8'hF0, TYP ? 96 : 32, 991, 991, 0, 'h55, 0);
    add(8'h55, TYP ? 96 : 32, 991, 991, 0, 'h55, 0);
    add(8'h55, TYP ? 128 : 64, 991, 991, 0, 'h55, 1);

    do_reset();
    @(negedge CLK_50);
    chk("rst.red",   int'(oRed),   0);
    chk("rst.green", int'(oGreen), 0);
    chk("rst.blue",  int'(oBlue),  0);
    chk("rst.sel",   int'(oSel),   0);
    chk("rst.key",   int'(oKey),   0);
    chk("rst.upd",   int'(oUpdate), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].code);
      chk($sformatf("vec%0d.red", i),   int'(oRed),   tbl[i].r);
      chk($sformatf("vec%0d.green", i), int'(oGreen), tbl[i].g);
      chk($sformatf("vec%0d.blue", i),  int'(oBlue),  tbl[i].b);
      chk($sformatf("vec%0d.sel", i),   int'(oSel),   tbl[i].sel);
      chk($sformatf("vec%0d.key", i),   int'(oKey),   tbl[i].key);
    end

    // Reset while a break prefix is pending: the following code must act as a make.
    send(8'h2D);
    send(8'hF0);
    do_reset();
    @(negedge CLK_50);
    chk("midrst.red", int'(oRed), 0);
    chk("midrst.key", int'(oKey), 0);
    send(8'h16);
    chk("midrst.make.red", int'(oRed), 100);
    chk("midrst.make.key", int'(oKey), 'h16);

    // Saturation on increment near full scale for the selected channel only.
    send(8'h34);
    send(8'h46);
    send(8'h45);
    send(8'h55);
    chk("sat.green", int'(oGreen), MAXV);
    chk("sat.red",   int'(oRed),   100);

    for (int n = 0; n < 150; n++) begin
      send(pool[$urandom_range(15, 0)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
